// File: rtl/status_xmit.sv
// -----------------------------------------------------------------------------
// status_xmit -- uplink serial status transmitter
//
// Purpose:
//   Return path of the downlink command receiver. It sends fault, self-check
//   and heartbeat frames from the PWM/driver board to the upper controller on
//   one wire. Three request sources are arbitrated with fixed priority:
//   fault > check > heartbeat. Priority is evaluated only when a frame is
//   loaded. Requests that arrive while a frame is in flight stay pending.
//
//   Frame, LSB first:
//     start(0), code[3:0], payload[15:0], [parity], stop(1)
//   This is followed by GAP_BITS idle bit-times.
//   Codes: 4'hA fault, 4'h5 check, 4'h3 heartbeat.
//
// Configuration macro:
//   PARITY_EN -- when defined, an even-parity bit over code+payload (20 bits)
//                follows the data bits, giving a 23-bit frame. When undefined,
//                the frame is 22 bits and there is no parity state.
//
// Parameters:
//   HB_DIV    clocks between heartbeat requests (>=1)
//   GAP_BITS  minimum idle bit-times between frames (>=1)
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-high
//   t[19:0]     bit period in clocks; values below 2 behave as 2;
//               latched at frame load
//   fault       global fault, level
//   fault1..4   per-leg driver faults, level
//   lockn       sync-lock status, reported in the heartbeat payload
//   check_data  self-check result word
//   check_vld   check_data valid; the source holds it until check_ack
//   check_ack   one-cycle pulse: check_data has been captured
//   txd         serial line, idle high
//   busy        high from frame load until the end of the inter-frame gap
// -----------------------------------------------------------------------------
module status_xmit #(
  parameter int HB_DIV   = 1000000,
  parameter int GAP_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] t,
  input  logic        fault,
  input  logic        fault1,
  input  logic        fault2,
  input  logic        fault3,
  input  logic        fault4,
  input  logic        lockn,
  input  logic [15:0] check_data,
  input  logic        check_vld,
  output logic        check_ack,
  output logic        txd,
  output logic        busy
);

  localparam int              HBW      = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
  localparam logic [HBW-1:0]  HB_LAST  = HBW'(HB_DIV - 1);
  localparam int              GW       = $clog2(GAP_BITS + 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_BITS - 1);
  localparam logic [4:0]      LAST_BIT = 5'd19;

  localparam logic [3:0] CODE_FAULT = 4'hA;
  localparam logic [3:0] CODE_CHECK = 4'h5;
  localparam logic [3:0] CODE_HB    = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_GAP
  } state_t;

  // Bit period saturates at 2 clocks so that every state lasts at least
  // two cycles and the bit-end compare below never underflows.
  function automatic logic [19:0] clamp_period(input logic [19:0] p);
    return (p < 20'd2) ? 20'd2 : p;
  endfunction

  state_t          state_q;
  logic            txd_q;
  logic            busy_q;
  logic            ack_q;
  logic [7:0]      seq_q;
  logic [4:0]      sticky_q;
  logic            fpend_q;
  logic            hbpend_q;
  logic [HBW-1:0]  hbcnt_q;
  logic [4:0]      fprev_q;
  logic            vld_q;
  logic [19:0]     cnt_q;
  logic [19:0]     tlat_q;
  logic [19:0]     sh_q;
  logic [4:0]      bitn_q;
  logic [GW-1:0]   gapn_q;
`ifdef PARITY_EN
  logic            par_q;
`endif

  logic [4:0]      fin;
  logic [4:0]      fedge;
  logic [4:0]      sticky_d;
  logic            fpend_d;
  logic            hbpend_d;
  logic [HBW-1:0]  hbcnt_d;
  logic            hb_exp;
  logic            idle;
  logic            ld_fault;
  logic            ld_check;
  logic            ld_hb;
  logic            load;
  logic            bit_end;
  logic [3:0]      code_sel;
  logic [15:0]     pay_sel;

  assign fin   = {fault4, fault3, fault2, fault1, fault};
  // fprev_q resets to all ones, so an input that is already high at reset
  // release does not look like a rising edge.
  assign fedge = fin & ~fprev_q;

  // The check request is taken from a registered copy of check_vld. A fault
  // edge that coincides with check_vld therefore becomes pending in the same
  // cycle as the check request, and the fault wins arbitration.
  assign idle     = (state_q == S_IDLE);
  assign ld_fault = idle & fpend_q;
  assign ld_check = idle & ~fpend_q & vld_q;
  assign ld_hb    = idle & ~fpend_q & ~vld_q & hbpend_q;
  assign load     = ld_fault | ld_check | ld_hb;

  // The load clears the sticky bits it reports. An edge in the same cycle is
  // OR'd in afterwards, so it survives for the next fault frame.
  assign sticky_d = (ld_fault ? 5'b0 : sticky_q) | fedge;
  assign fpend_d  = (fpend_q & ~ld_fault) | (|fedge);

  // Free-running heartbeat divider. An expiry while a heartbeat is already
  // pending has no further effect.
  assign hb_exp   = (hbcnt_q == HB_LAST);
  assign hbcnt_d  = hb_exp ? '0 : hbcnt_q + 1'b1;
  assign hbpend_d = (hbpend_q & ~ld_hb) | hb_exp;

  assign bit_end = (cnt_q == (tlat_q - 20'd1));

  always_comb begin
    code_sel = CODE_HB;
    pay_sel  = {lockn, 7'b0, seq_q};
    if (fpend_q) begin
      code_sel = CODE_FAULT;
      pay_sel  = {11'b0, sticky_q};
    end else if (vld_q) begin
      code_sel = CODE_CHECK;
      pay_sel  = check_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      seq_q    <= 8'd0;
      sticky_q <= 5'b0;
      fpend_q  <= 1'b0;
      hbpend_q <= 1'b0;
      hbcnt_q  <= '0;
      fprev_q  <= 5'b11111;
      vld_q    <= 1'b0;
      cnt_q    <= 20'd0;
      tlat_q   <= 20'd2;
      sh_q     <= 20'd0;
      bitn_q   <= 5'd0;
      gapn_q   <= '0;
`ifdef PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      fprev_q  <= fin;
      vld_q    <= check_vld;
      sticky_q <= sticky_d;
      fpend_q  <= fpend_d;
      hbcnt_q  <= hbcnt_d;
      hbpend_q <= hbpend_d;
      ack_q    <= ld_check;

      case (state_q)
        S_IDLE: begin
          if (load) begin
            sh_q    <= {pay_sel, code_sel};
`ifdef PARITY_EN
            par_q   <= ^{pay_sel, code_sel};
`endif
            tlat_q  <= clamp_period(t);
            cnt_q   <= 20'd0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            cnt_q   <= 20'd0;
            txd_q   <= sh_q[0];
            sh_q    <= {1'b0, sh_q[19:1]};
            bitn_q  <= 5'd0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt_q <= 20'd0;
            if (bitn_q == LAST_BIT) begin
`ifdef PARITY_EN
              txd_q   <= par_q;
              state_q <= S_PAR;
`else
              txd_q   <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bitn_q <= bitn_q + 5'd1;
              txd_q  <= sh_q[0];
              sh_q   <= {1'b0, sh_q[19:1]};
            end
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end

`ifdef PARITY_EN
        S_PAR: begin
          if (bit_end) begin
            cnt_q   <= 20'd0;
            txd_q   <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            cnt_q   <= 20'd0;
            seq_q   <= seq_q + 8'd1;
            gapn_q  <= '0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end

        S_GAP: begin
          if (bit_end) begin
            cnt_q <= 20'd0;
            if (gapn_q == GAP_LAST) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              gapn_q <= gapn_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end

        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign txd       = txd_q;
  assign busy      = busy_q;
  assign check_ack = ack_q;

endmodule

// File: tb/tb_status_xmit.sv
module tb_status_xmit;

`ifdef PARITY_EN
  localparam int NB = 23;
`else
  localparam int NB = 22;
`endif

  logic        clk;
  logic        rst;
  logic [19:0] t;
  logic [4:0]  fv;
  logic        lockn;
  logic [15:0] check_data;
  logic        check_vld;
  logic        check_ack;
  logic        txd;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int acks     = 0;

  status_xmit #(.HB_DIV(100), .GAP_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .t          (t),
    .fault      (fv[0]),
    .fault1     (fv[1]),
    .fault2     (fv[2]),
    .fault3     (fv[3]),
    .fault4     (fv[4]),
    .lockn      (lockn),
    .check_data (check_data),
    .check_vld  (check_vld),
    .check_ack  (check_ack),
    .txd        (txd),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit, then samples every bit at mid-period.
  // At relative cycle act_cyc, ORs fmask into the fault inputs for one cycle
  // and drives t to tnew.
  task automatic rx_frame(input int P, input int act_cyc, input logic [4:0] fmask,
                          input logic [19:0] tnew,
                          output logic [3:0] code, output logic [15:0] pay,
                          output logic par, output logic stp, output int slen,
                          output logic ack0, output int wn);
    logic [22:0] bits;
    logic        found;
    logic        lowrun;
    logic [4:0]  fsave;
    bits   = '0;
    found  = 1'b0;
    wn     = 0;
    slen   = 0;
    lowrun = 1'b1;
    fsave  = fv;
    par    = 1'b0;
    while (!found && wn < 400) begin
      @(negedge clk);
      wn++;
      if (txd === 1'b0) found = 1'b1;
    end
    check("frame_start", {31'b0, found}, 32'd1);
    check("busy_at_start", {31'b0, busy}, 32'd1);
    ack0 = check_ack;
    for (int c = 0; c < NB * P; c++) begin
      if (c == act_cyc) begin
        fsave = fv;
        fv    = fv | fmask;
        t     = tnew;
      end
      if (c == act_cyc + 1) fv = fsave;
      if (lowrun && txd === 1'b0) slen++;
      else lowrun = 1'b0;
      if (c % P == P / 2) bits[c / P] = txd;
      if (check_ack === 1'b1) begin
        acks++;
        check_vld = 1'b0;
      end
      @(negedge clk);
    end
    code = bits[4:1];
    pay  = bits[20:5];
`ifdef PARITY_EN
    par  = bits[21];
    stp  = bits[22];
    check("parity_even", {31'b0, par}, {31'b0, ^{pay, code}});
`else
    stp  = bits[21];
`endif
  endtask

  task automatic expect_frame(input string tg, input logic [3:0] code, input logic [15:0] pay,
                              input logic stp, input logic [3:0] ec, input logic [15:0] ep);
    check({tg, "_code"}, {28'b0, code}, {28'b0, ec});
    check({tg, "_payload"}, {16'b0, pay}, {16'b0, ep});
    check({tg, "_stop"}, {31'b0, stp}, 32'd1);
  endtask

  initial begin
    logic [3:0]  code;
    logic [15:0] pay;
    logic        par;
    logic        stp;
    logic        ack0;
    logic        bad;
    logic        found;
    int          slen;
    int          wn;
    int          w;

    rst = 1'b1; t = 20'd4; fv = 5'b0; lockn = 1'b1;
    check_data = 16'h0; check_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ack", {31'b0, check_ack}, 32'd0);

    // Idle until the first heartbeat expiry
    rst = 1'b0;
    bad = 1'b0;
    repeat (90) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("idle_before_hb", {31'b0, bad}, 32'd0);

    // Heartbeats: seq 0 then 1; fault2 pulse during the second
    rx_frame(4, -1, 5'b0, 20'd4, code, pay, par, stp, slen, ack0, wn);
    check("hb_first_start_wait", wn, 32'd11);
    check("hbA_startlen", slen, 32'd4);
    expect_frame("hbA", code, pay, stp, 4'h3, 16'h8000);
    rx_frame(4, 10, 5'b00100, 20'd4, code, pay, par, stp, slen, ack0, wn);
    expect_frame("hbB", code, pay, stp, 4'h3, 16'h8001);
    rx_frame(4, -1, 5'b0, 20'd4, code, pay, par, stp, slen, ack0, wn);
    expect_frame("fault2", code, pay, stp, 4'hA, 16'h0004);
    rx_frame(4, -1, 5'b0, 20'd4, code, pay, par, stp, slen, ack0, wn);
    expect_frame("hbD", code, pay, stp, 4'h3, 16'h8003);

    // Simultaneous check request and fault1 rise while idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (3) @(negedge clk);
    check_data = 16'hBEEF; check_vld = 1'b1; fv[1] = 1'b1;
    rx_frame(4, -1, 5'b0, 20'd4, code, pay, par, stp, slen, ack0, wn);
    expect_frame("fault1", code, pay, stp, 4'hA, 16'h0002);
    check("no_ack_during_fault", acks, 32'd0);
    rx_frame(4, -1, 5'b0, 20'd4, code, pay, par, stp, slen, ack0, wn);
    expect_frame("check", code, pay, stp, 4'h5, 16'hBEEF);
    check("ack_at_check_load", {31'b0, ack0}, 32'd1);
    check("ack_count", acks, 32'd1);

    // Bit-period clamp and mid-frame change of t
    t = 20'd1;
    rx_frame(2, -1, 5'b0, 20'd1, code, pay, par, stp, slen, ack0, wn);
    check("t1_startlen", slen, 32'd2);
    expect_frame("hb_t1", code, pay, stp, 4'h3, 16'h8002);
    t = 20'd4;
    rx_frame(4, 10, 5'b0, 20'd8, code, pay, par, stp, slen, ack0, wn);
    check("t4_startlen", slen, 32'd4);
    expect_frame("hb_t4", code, pay, stp, 4'h3, 16'h8003);
    rx_frame(8, -1, 5'b0, 20'd8, code, pay, par, stp, slen, ack0, wn);
    check("t8_startlen", slen, 32'd8);
    expect_frame("hb_t8", code, pay, stp, 4'h3, 16'h8004);

    // Asynchronous reset in the middle of the data bits
    t = 20'd4;
    found = 1'b0;
    w = 0;
    while (!found && w < 400) begin
      @(negedge clk);
      w++;
      if (txd === 1'b0) found = 1'b1;
    end
    check("midrst_frame_start", {31'b0, found}, 32'd1);
    repeat (9) @(negedge clk);
    check("busy_mid_data", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_txd", {31'b0, txd}, 32'd1);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_ack", {31'b0, check_ack}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("no_resume_after_rst", {31'b0, bad}, 32'd0);

    // fault1 was already high through reset release: the check frame goes first
    check_data = 16'h0001; check_vld = 1'b1;
    rx_frame(4, -1, 5'b0, 20'd4, code, pay, par, stp, slen, ack0, wn);
    expect_frame("check1", code, pay, stp, 4'h5, 16'h0001);
    check("check1_ack", {31'b0, ack0}, 32'd1);
`ifdef PARITY_EN
    check("check1_par", {31'b0, par}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
